inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the core's immediate decode path: packs a format tag, register/funct fields and a 32-bit signed immediate into a 32-bit RV32I instruction word.
- Checks that the immediate is representable in the selected format; unrepresentable requests produce a NOP and an error flag.
- Sits between the test/boot loader and instruction memory writes, with valid/ready handshakes on both sides.
- Two-stage pipeline: S1 captures and range-checks; S2 packs and holds the output.

Parameters:
CNT_W, 16, width of the saturating encoded/error counters
NOP_WORD, 32'h00000013, word emitted on error (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_fmt  in  3  0=R,1=I,2=S,3=B,4=U,5=J,6/7 illegal
in_opcode  in  7  opcode, placed at [6:0] unchanged
in_rd, in_rs1, in_rs2  in  5 each  register fields
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R only)
in_imm  in  32  signed immediate, byte offset for B/J, full value for U
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
out_inst  out  32  encoded instruction
out_err  out  1  request was unrepresentable; out_inst = NOP_WORD
enc_count  out  CNT_W  accepted requests that encoded OK, saturating
err_count  out  CNT_W  accepted requests flagged error, saturating

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: s1_valid=0, out_valid=0, out_inst=0, out_err=0, enc_count=0, err_count=0. in_ready=1 once s1 is empty.
- Assertion of rst_n mid-transfer discards both stages; no partial word is emitted after release.
- Handshake:
  - S2 advances when !out_valid || out_ready.
  - S1 advances into S2 on the same condition.
  - in_ready = !s1_valid || S2 advances, which is a combinational path from out_ready.
  - Full throughput is one word per cycle.
  - Latency from accept to out_valid is 2 cycles when not stalled.
- Outputs and stalls:
  - out_inst and out_err are stable while out_valid && !out_ready.
  - No request is dropped or duplicated under any out_ready pattern.
- S1 captures all inputs and computes err:
  - I, S: err if imm outside [-2048, 2047].
  - B: err if imm[0]!=0 or imm outside [-4096, 4094].
  - J: err if imm[0]!=0 or imm outside [-1048576, 1048574].
  - U: err if imm[11:0]!=0.
  - R: imm ignored, never err.
  - fmt 6/7: err.
- S2 packing; opcode is always at [6:0]:
  - R: funct7|rs2|rs1|funct3|rd.
  - I: imm[11:0]|rs1|funct3|rd.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0].
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11].
  - U: imm[31:12]|rd.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd.
  - If err: out_inst=NOP_WORD, out_err=1.
- Counters: increment when a word is loaded into S2, not on output handshake. They saturate at all-ones and do not wrap.
- Signed range checks are done on the full 32-bit input. Boundary values are inclusive.

Decomposition:
- Shared package rv_enc_pkg:
  - fmt_e enum (FMT_R..FMT_J).
  - Opcode constants: OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_R.
  - Range limit localparams.
  - Struct enc_req_t holding the captured S1 fields.
- One sub-module, imm_pack: combinational fmt+fields+imm -> instruction word. It is reused by the bench as a golden model and round-trip checked against the core's immediate decoder.

Test Plan:
- fmt=I, opcode=0010011, rd=1, rs1=2, funct3=0, imm=-1, out_ready=1 -> out_inst=32'hFFF10093, out_err=0, out_valid exactly 2 cycles after accept, enc_count=1.
- fmt=B, opcode=1100011, rs1=1, rs2=2, funct3=0, imm=4094 then 4096 -> first word round-trips to imm=4094; second out_err=1, out_inst=32'h00000013, err_count=1.
- fmt=J, imm=3 (odd) -> out_err=1; fmt=U, imm=32'h12345000, rd=5, opcode=0110111 -> out_inst=32'h123452B7.
- Back-to-back 8 requests with out_ready toggling 1,0,0,1,... -> all 8 words emitted in order, none lost or duplicated, out_inst held stable while stalled, in_ready low only when both stages are full and stalled.
- rst_n pulsed low asynchronously (between edges) while both stages hold valid words -> out_valid=0, counters=0 immediately; first post-reset request emitted correctly with latency 2.
- CNT_W=2, 5 legal requests -> enc_count saturates at 3 and never wraps.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder: format tags,
// opcodes, immediate range limits and the captured request record.
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  // Inclusive signed limits; B/J maxima are the largest even offsets.
  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMM_B_MIN = -4096;
  localparam int signed IMM_B_MAX = 4094;
  localparam int signed IMM_J_MIN = -1048576;
  localparam int signed IMM_J_MAX = 1048574;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        err;
  } enc_req_t;

  function automatic logic imm_unrepresentable(input logic [2:0] fmt, input logic [31:0] imm);
    logic signed [31:0] v;
    v = $signed(imm);
    case (fmt)
      FMT_R:        return 1'b0;
      FMT_I, FMT_S: return (v < IMM12_MIN) || (v > IMM12_MAX);
      FMT_B:        return imm[0] || (v < IMM_B_MIN) || (v > IMM_B_MAX);
      FMT_J:        return imm[0] || (v < IMM_J_MIN) || (v > IMM_J_MAX);
      FMT_U:        return imm[11:0] != 12'd0;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational packer: scatters register/funct fields and immediate bits
// into the RV32I word layout of the selected format, or emits NOP on error.
module imm_pack
  import rv_enc_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  enc_req_t    req,
  output logic [31:0] inst
);

  always_comb begin
    inst = NOP_WORD;
    if (!req.err) begin
      case (req.fmt)
        FMT_R: inst = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
        FMT_I: inst = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        FMT_S: inst = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
        FMT_B: inst = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                       req.imm[4:1], req.imm[11], req.opcode};
        FMT_U: inst = {req.imm[31:12], req.rd, req.opcode};
        FMT_J: inst = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                       req.rd, req.opcode};
        default: inst = NOP_WORD;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder: S1 captures and range-checks the
// request, S2 packs it and holds the word until the downstream accepts.
module inst_encoder
  import rv_enc_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and a held word stays unchanged.
  logic             s1_valid_q, s1_valid_d;
  enc_req_t         s1_req_q, s1_req_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_inst_q, out_inst_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic        s2_adv;
  logic        s2_load;
  logic        in_fire;
  logic [31:0] packed_inst;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s2_adv && s1_valid_q;

  imm_pack #(.NOP_WORD(NOP_WORD)) u_pack (
    .req  (s1_req_q),
    .inst (packed_inst)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_req_d   = s1_req_q;
    if (in_fire) begin
      s1_valid_d      = 1'b1;
      s1_req_d.fmt    = in_fmt;
      s1_req_d.opcode = in_opcode;
      s1_req_d.rd     = in_rd;
      s1_req_d.rs1    = in_rs1;
      s1_req_d.rs2    = in_rs2;
      s1_req_d.funct3 = in_funct3;
      s1_req_d.funct7 = in_funct7;
      s1_req_d.imm    = in_imm;
      s1_req_d.err    = imm_unrepresentable(in_fmt, in_imm);
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Counters track words entering S2, independent of the output handshake.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (s2_adv) out_valid_d = s1_valid_q;
    if (s2_load) begin
      out_inst_d = packed_inst;
      out_err_d  = s1_req_q.err;
      if (s1_req_q.err) begin
        if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + CNT_W'(1);
      end else begin
        if (enc_count_q != {CNT_W{1'b1}}) enc_count_d = enc_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-computed encodings, range boundaries,
// stall/throughput ordering, asynchronous reset and counter saturation.
module tb_inst_encoder;
  import rv_enc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst;
  logic [15:0] enc_count, err_count;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_out_inst;
  logic [1:0]  s_enc_count, s_err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_enc  = 0;
  int exp_errc = 0;
  logic [32:0] exp_q[$];

  inst_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  inst_encoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_fmt(FMT_I), .in_opcode(OP_IMM), .in_rd(5'd1), .in_rs1(5'd0),
    .in_rs2(5'd0), .in_funct3(3'd0), .in_funct7(7'd0), .in_imm(32'd1),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_inst(s_out_inst), .out_err(s_out_err),
    .enc_count(s_enc_count), .err_count(s_err_count)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
    int          rt;   // 0: none, 1: B round trip, 2: J round trip
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] inst, input logic err, input int rt, input string name);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.inst = inst; v.err = err; v.rt = rt; v.name = name;
    return v;
  endfunction

  function automatic logic [31:0] dec_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] dec_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; s_in_valid = 1'b0;
    set_req(FMT_R, OP_R, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'd0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b inst=%h err=%b, want 0/00000000/0", out_valid, out_inst, out_err);
    end
    n_checks++;
    if (enc_count !== 16'd0 || err_count !== 16'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_counts: got enc=%0d err=%0d in_ready=%b, want 0/0/1", enc_count, err_count, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_encode_vectors();
    vec_t vecs[$];
    vecs.push_back(mk(FMT_I, OP_IMM,    5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0, 0, "i_neg1"));
    vecs.push_back(mk(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094,     32'h7E208FE3, 1'b0, 1, "b_4094"));
    vecs.push_back(mk(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096,     32'h00000013, 1'b1, 0, "b_4096"));
    vecs.push_back(mk(FMT_J, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h00000013, 1'b1, 0, "j_odd"));
    vecs.push_back(mk(FMT_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0, 0, "u_lui"));
    vecs.push_back(mk(FMT_I, OP_IMM,    5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2047,     32'h7FF10093, 1'b0, 0, "i_max"));
    vecs.push_back(mk(FMT_I, OP_IMM,    5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFF7FF, 32'h00000013, 1'b1, 0, "i_under"));
    vecs.push_back(mk(FMT_S, OP_STORE,  5'd0, 5'd4, 5'd3, 3'd2, 7'd0, 32'hFFFFF800, 32'h80322023, 1'b0, 0, "s_min"));
    vecs.push_back(mk(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFF000, 32'h80208063, 1'b0, 1, "b_min"));
    vecs.push_back(mk(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5,        32'h00000013, 1'b1, 0, "b_odd"));
    vecs.push_back(mk(FMT_J, OP_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574,  32'h7FFFF06F, 1'b0, 2, "j_max"));
    vecs.push_back(mk(FMT_J, OP_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576,  32'h00000013, 1'b1, 0, "j_over"));
    vecs.push_back(mk(FMT_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h00000013, 1'b1, 0, "u_lowbits"));
    vecs.push_back(mk(FMT_R, OP_R,      5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEADBEEF, 32'h403100B3, 1'b0, 0, "r_sub"));
    vecs.push_back(mk(3'd6,  OP_IMM,    5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0,        32'h00000013, 1'b1, 0, "fmt6"));
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      @(negedge clk);
      set_req(vecs[k].fmt, vecs[k].op, vecs[k].rd, vecs[k].rs1, vecs[k].rs2, vecs[k].f3, vecs[k].f7, vecs[k].imm);
      in_valid = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_in_ready: got %b, want 1", vecs[k].name, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_early_valid: got out_valid=%b one cycle after accept, want 0", vecs[k].name, out_valid);
      end
      @(negedge clk);
      if (vecs[k].err) exp_errc++; else exp_enc++;
      n_checks++;
      if (out_valid !== 1'b1 || out_inst !== vecs[k].inst || out_err !== vecs[k].err) begin
        n_fail++;
        $display("FAIL %s_word: got valid=%b inst=%h err=%b, want 1/%h/%b",
                 vecs[k].name, out_valid, out_inst, out_err, vecs[k].inst, vecs[k].err);
      end
      n_checks++;
      if (enc_count !== 16'(exp_enc) || err_count !== 16'(exp_errc)) begin
        n_fail++;
        $display("FAIL %s_counts: got enc=%0d err=%0d, want %0d/%0d", vecs[k].name, enc_count, err_count, exp_enc, exp_errc);
      end
      if (vecs[k].rt == 1) begin
        n_checks++;
        if (dec_b(out_inst) !== vecs[k].imm) begin
          n_fail++;
          $display("FAIL %s_roundtrip: got imm=%h, want %h", vecs[k].name, dec_b(out_inst), vecs[k].imm);
        end
      end else if (vecs[k].rt == 2) begin
        n_checks++;
        if (dec_j(out_inst) !== vecs[k].imm) begin
          n_fail++;
          $display("FAIL %s_roundtrip: got imm=%h, want %h", vecs[k].name, dec_j(out_inst), vecs[k].imm);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int sent = 0, recv = 0, cyc = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_inst = '0;
    logic [31:0] imm;
    logic [32:0] exp_w;
    logic take, acc, exp_ready;
    exp_q.delete();
    while (recv < 8 && cyc < 100) begin
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_inst !== prev_inst) begin
          n_fail++;
          $display("FAIL b2b_hold: got valid=%b inst=%h, want 1/%h", out_valid, out_inst, prev_inst);
        end
      end
      out_ready = (cyc % 3 == 0);
      imm = 32'(sent * 100 - 300);
      set_req(FMT_I, OP_IMM, 5'(sent + 1), 5'(sent), 5'd0, 3'(sent), 7'd0, imm);
      in_valid = (sent < 8);
      #1;
      exp_ready = !((sent - recv) == 2 && !out_ready);
      n_checks++;
      if (in_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL b2b_in_ready: cycle %0d got %b, want %b", cyc, in_ready, exp_ready);
      end
      take = out_valid && out_ready;
      acc  = in_valid && in_ready;
      if (take) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got unexpected word %h, want none", out_inst);
        end else begin
          exp_w = exp_q.pop_front();
          if ({out_err, out_inst} !== exp_w) begin
            n_fail++;
            $display("FAIL b2b_word%0d: got err=%b inst=%h, want %b/%h", recv, out_err, out_inst, exp_w[32], exp_w[31:0]);
          end
        end
        recv++;
      end
      if (acc) begin
        exp_q.push_back({1'b0, imm[11:0], 5'(sent), 3'(sent), 5'(sent + 1), OP_IMM});
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_inst  = out_inst;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp_enc += 8;
    n_checks++;
    if (recv != 8 || exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_complete: got recv=%0d pending=%0d valid=%b, want 8/0/0", recv, exp_q.size(), out_valid);
    end
    n_checks++;
    if (enc_count !== 16'(exp_enc)) begin
      n_fail++;
      $display("FAIL b2b_enc_count: got %0d, want %0d", enc_count, exp_enc);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    @(negedge clk);
    set_req(FMT_I, OP_IMM, 5'd3, 5'd1, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    @(negedge clk);
    set_req(FMT_I, OP_IMM, 5'd4, 5'd1, 5'd0, 3'd0, 7'd0, 32'd6);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_preload: got valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_enc = 0; exp_errc = 0;
    n_checks++;
    if (out_valid !== 1'b0 || enc_count !== 16'd0 || err_count !== 16'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: got valid=%b enc=%0d err=%0d in_ready=%b, want 0/0/0/1", out_valid, enc_count, err_count, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_stale: got out_valid=%b after release, want 0", out_valid);
    end
    set_req(FMT_I, OP_IMM, 5'd4, 5'd1, 5'd0, 3'd0, 7'd0, 32'd7);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_latency1: got out_valid=%b, want 0", out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h00708213 || out_err !== 1'b0 || enc_count !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_first_word: got valid=%b inst=%h err=%b enc=%0d, want 1/00708213/0/1", out_valid, out_inst, out_err, enc_count);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    int exp_sat;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b0;
      @(negedge clk);
      exp_sat = (n > 3) ? 3 : n;
      n_checks++;
      if (s_enc_count !== 2'(exp_sat) || s_out_inst !== 32'h00100093) begin
        n_fail++;
        $display("FAIL sat_enc%0d: got enc=%0d inst=%h, want %0d/00100093", n, s_enc_count, s_out_inst, exp_sat);
      end
    end
    n_checks++;
    if (s_err_count !== 2'd0) begin
      n_fail++;
      $display("FAIL sat_err_count: got %0d, want 0", s_err_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encode_vectors();
    test_back_to_back();
    test_async_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
